// File: rtl/pipe_ctrl_pkg.sv
// Shared instruction-field layout, opcode/ALU-op constants and FSM state type
// for the pipeline hazard and stall controller.
package pipe_ctrl_pkg;

    localparam int INSTR_W = 32;
    localparam int CNT_W   = 16;
    localparam int REG_W   = 5;

    localparam logic [4:0] OP_ALU  = 5'b00000;
    localparam logic [4:0] OP_LW   = 5'b01000;
    localparam logic [4:0] OP_SW   = 5'b00111;
    localparam logic [4:0] OP_BNE  = 5'b00010;
    localparam logic [4:0] OP_BLT  = 5'b00110;

    localparam logic [4:0] ALU_MUL = 5'b00110;
    localparam logic [4:0] ALU_DIV = 5'b00111;

    typedef struct packed {
        logic [4:0]       opcode;
        logic [REG_W-1:0] rd;
        logic [REG_W-1:0] rs;
        logic [REG_W-1:0] rt;
        logic [4:0]       shamt;
        logic [4:0]       alu_op;
        logic [1:0]       lo;
    } instr_t;

    typedef logic [0:0] state_t;

    localparam state_t ST_IDLE    = 1'b0;
    localparam state_t ST_MD_BUSY = 1'b1;

    // sw, bne and blt read their rd field as a source operand
    function automatic logic reads_rd(input logic [4:0] opcode);
        return (opcode == OP_SW) || (opcode == OP_BNE) || (opcode == OP_BLT);
    endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Signal bundle between the datapath (master) and the stall/flush
// controller (slave).
interface pipeline_ctrl_if;
    import pipe_ctrl_pkg::*;

    logic [INSTR_W-1:0] ir_fd;
    logic [INSTR_W-1:0] ir_dx;
    logic               branch_taken;
    logic               md_ready;
    logic               freeze;

    logic               pc_en;
    logic               fd_block;
    logic               dx_block;
    logic               xm_block;
    logic               mw_block;
    logic               fd_flush;
    logic               dx_flush;
    logic               xm_flush;
    logic               mw_flush;
    logic               md_start;
    logic [CNT_W-1:0]   stall_count;

    modport master (
        output ir_fd, ir_dx, branch_taken, md_ready, freeze,
        input  pc_en, fd_block, dx_block, xm_block, mw_block,
        input  fd_flush, dx_flush, xm_flush, mw_flush, md_start, stall_count
    );

    modport slave (
        input  ir_fd, ir_dx, branch_taken, md_ready, freeze,
        output pc_en, fd_block, dx_block, xm_block, mw_block,
        output fd_flush, dx_flush, xm_flush, mw_flush, md_start, stall_count
    );

endinterface

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Combinational classification of the FD/DX instruction pair: load-use
// dependency and multdiv detection.
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [INSTR_W-1:0] ir_fd,
    input  logic [INSTR_W-1:0] ir_dx,
    output logic               load_use,
    output logic               is_multdiv
);

    instr_t fd;
    instr_t dx;
    logic   rd_hit_rs;
    logic   rd_hit_rt;
    logic   rd_hit_rd;
    logic   unused_fields;

    assign fd = instr_t'(ir_fd);
    assign dx = instr_t'(ir_dx);

    assign is_multdiv = (dx.opcode == OP_ALU) &&
                        ((dx.alu_op == ALU_MUL) || (dx.alu_op == ALU_DIV));

    assign rd_hit_rs = (fd.rs == dx.rd);
    assign rd_hit_rt = (fd.opcode == OP_ALU) && (fd.rt == dx.rd);
    assign rd_hit_rd = reads_rd(fd.opcode) && (fd.rd == dx.rd);

    // r0 is hardwired to zero, so a load into it never creates a dependency
    assign load_use  = (dx.opcode == OP_LW) && (dx.rd != '0) &&
                       (rd_hit_rs || rd_hit_rt || rd_hit_rd);

    assign unused_fields = ^{fd.shamt, fd.alu_op, fd.lo,
                             dx.rs, dx.rt, dx.shamt, dx.lo};

endmodule

// File: rtl/pipeline_ctrl.sv
// Five-stage pipeline stall/flush controller: load-use stalls, branch
// flushes, multdiv hold FSM, external freeze and a saturating stall counter.
module pipeline_ctrl
    import pipe_ctrl_pkg::*;
(
    input  logic           clock,
    input  logic           reset_n,
    pipeline_ctrl_if.slave bus
);

    logic             load_use;
    logic             is_multdiv;
    state_t           state;
    state_t           state_nxt;
    logic             md_done;
    logic             md_done_nxt;
    logic             pc_en;
    logic             fd_block;
    logic             dx_block;
    logic             xm_block;
    logic             mw_block;
    logic             fd_flush;
    logic             dx_flush;
    logic             xm_flush;
    logic             mw_flush;
    logic             md_start;
    logic [CNT_W-1:0] stall_count;

    hazard_detect u_hazard_detect (
        .ir_fd      (bus.ir_fd),
        .ir_dx      (bus.ir_dx),
        .load_use   (load_use),
        .is_multdiv (is_multdiv)
    );

    // Priority: reset > freeze > multdiv hold > branch > load-use > normal
    always_comb begin
        pc_en       = 1'b1;
        fd_block    = 1'b0;
        dx_block    = 1'b0;
        xm_block    = 1'b0;
        mw_block    = 1'b0;
        fd_flush    = 1'b0;
        dx_flush    = 1'b0;
        xm_flush    = 1'b0;
        mw_flush    = 1'b0;
        md_start    = 1'b0;
        state_nxt   = state;
        md_done_nxt = (state == ST_MD_BUSY) && (md_done || bus.md_ready);

        if (!reset_n) begin
            pc_en       = 1'b0;
            fd_flush    = 1'b1;
            dx_flush    = 1'b1;
            xm_flush    = 1'b1;
            mw_flush    = 1'b1;
            state_nxt   = ST_IDLE;
            md_done_nxt = 1'b0;
        end else if (bus.freeze) begin
            pc_en    = 1'b0;
            fd_block = 1'b1;
            dx_block = 1'b1;
            xm_block = 1'b1;
            mw_block = 1'b1;
        end else if (state == ST_MD_BUSY) begin
            // Release cycle: everything flows so XM captures the multdiv result
            if (bus.md_ready || md_done) begin
                state_nxt   = ST_IDLE;
                md_done_nxt = 1'b0;
            end else begin
                pc_en    = 1'b0;
                fd_block = 1'b1;
                dx_block = 1'b1;
                xm_flush = 1'b1;
            end
        end else if (is_multdiv && !bus.branch_taken) begin
            md_start  = 1'b1;
            pc_en     = 1'b0;
            fd_block  = 1'b1;
            dx_block  = 1'b1;
            xm_flush  = 1'b1;
            state_nxt = ST_MD_BUSY;
        end else if (bus.branch_taken) begin
            fd_flush = 1'b1;
            dx_flush = 1'b1;
        end else if (load_use) begin
            pc_en    = 1'b0;
            fd_block = 1'b1;
            dx_flush = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            md_done <= 1'b0;
        end else begin
            state   <= state_nxt;
            md_done <= md_done_nxt;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stall_count <= '0;
        end else if (!pc_en && !bus.freeze && (stall_count != '1)) begin
            stall_count <= stall_count + 1'b1;
        end
    end

    assign bus.pc_en       = pc_en;
    assign bus.fd_block    = fd_block;
    assign bus.dx_block    = dx_block;
    assign bus.xm_block    = xm_block;
    assign bus.mw_block    = mw_block;
    assign bus.fd_flush    = fd_flush;
    assign bus.dx_flush    = dx_flush;
    assign bus.xm_flush    = xm_flush;
    assign bus.mw_flush    = mw_flush;
    assign bus.md_start    = md_start;
    assign bus.stall_count = stall_count;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: directed hazard scenarios plus random
// traffic, checked every cycle against a behavioural model.
module tb_pipeline_ctrl;

    typedef struct packed {
        logic pc_en;
        logic fd_block;
        logic dx_block;
        logic xm_block;
        logic mw_block;
        logic fd_flush;
        logic dx_flush;
        logic xm_flush;
        logic mw_flush;
        logic md_start;
    } ctl_t;

    typedef struct packed {
        ctl_t        c;
        logic [15:0] cnt;
    } exp_t;

    logic clock = 1'b0;
    logic reset_n;

    pipeline_ctrl_if bus ();

    pipeline_ctrl dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb_q[$];

    // model state
    bit   m_busy = 1'b0;
    bit   m_done = 1'b0;
    int   m_count = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic ctl_t mk(input bit pc, fb, db, xb, mb, ff, df, xf, mf, ms);
        ctl_t c;
        c = '{pc, fb, db, xb, mb, ff, df, xf, mf, ms};
        return c;
    endfunction

    function automatic logic [31:0] r_ins(input int op, rd, rs, rt, alu);
        logic [31:0] w;
        w = (op << 27) | (rd << 22) | (rs << 17) | (rt << 12) | (alu << 2);
        return w;
    endfunction

    function automatic bit m_is_md(input logic [31:0] ir);
        int op, alu;
        op  = int'(ir >> 27);
        alu = int'((ir >> 2) & 32'h1f);
        return (op == 0) && (alu == 6 || alu == 7);
    endfunction

    function automatic bit m_load_use(input logic [31:0] fd, input logic [31:0] dx);
        int dop, drd, fop, frd, frs, frt;
        dop = int'(dx >> 27);
        drd = int'((dx >> 22) & 32'h1f);
        fop = int'(fd >> 27);
        frd = int'((fd >> 22) & 32'h1f);
        frs = int'((fd >> 17) & 32'h1f);
        frt = int'((fd >> 12) & 32'h1f);
        if (dop != 8 || drd == 0) return 1'b0;
        if (frs == drd) return 1'b1;
        if (fop == 0 && frt == drd) return 1'b1;
        if ((fop == 7 || fop == 2 || fop == 6) && frd == drd) return 1'b1;
        return 1'b0;
    endfunction

    // One clock cycle of stimulus; the model predicts this cycle's outputs
    task automatic cyc(input logic [31:0] fd, input logic [31:0] dx,
                       input logic br, input logic mdr, input logic frz, input logic rn);
        ctl_t e;
        bit   leave, enter;
        exp_t x;
        @(posedge clock);
        #1;
        bus.ir_fd        = fd;
        bus.ir_dx        = dx;
        bus.branch_taken = br;
        bus.md_ready     = mdr;
        bus.freeze       = frz;
        reset_n          = rn;
        leave = 1'b0;
        enter = 1'b0;
        e = mk(1,0,0,0,0,0,0,0,0,0);
        if (!rn) begin
            e = mk(0,0,0,0,0,1,1,1,1,0);
            m_busy = 1'b0;
            m_done = 1'b0;
            m_count = 0;
        end else if (frz) begin
            e = mk(0,1,1,1,1,0,0,0,0,0);
            if (m_busy && mdr) m_done = 1'b1;
        end else if (m_busy) begin
            if (mdr || m_done) leave = 1'b1;
            else e = mk(0,1,1,0,0,0,0,1,0,0);
        end else if (m_is_md(dx) && !br) begin
            e = mk(0,1,1,0,0,0,0,1,0,1);
            enter = 1'b1;
        end else if (br) begin
            e = mk(1,0,0,0,0,1,1,0,0,0);
        end else if (m_load_use(fd, dx)) begin
            e = mk(0,1,0,0,0,0,1,0,0,0);
        end
        x.c   = e;
        x.cnt = 16'(m_count);
        sb_q.push_back(x);
        if (rn) begin
            if (!frz && !e.pc_en && m_count < 65535) m_count++;
            if (leave) begin
                m_busy = 1'b0;
                m_done = 1'b0;
            end
            if (enter) m_busy = 1'b1;
        end
    endtask

    function automatic logic [31:0] rnd_instr();
        logic [4:0] op;
        int         alu;
        case ($urandom_range(0, 5))
            0:       op = 5'b00000;
            1:       op = 5'b01000;
            2:       op = 5'b00111;
            3:       op = 5'b00010;
            4:       op = 5'b00110;
            default: op = 5'b00101;
        endcase
        alu = ($urandom_range(0, 3) == 0) ? 6 + int'($urandom_range(0, 1)) : int'($urandom_range(0, 5));
        return r_ins(int'(op), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 3)), alu);
    endfunction

    // Monitor: compare whatever the DUT presents against the queued prediction
    always @(negedge clock) begin
        exp_t x;
        ctl_t a;
        if (sb_q.size() > 0) begin
            x = sb_q.pop_front();
            a = '{bus.pc_en, bus.fd_block, bus.dx_block, bus.xm_block, bus.mw_block,
                  bus.fd_flush, bus.dx_flush, bus.xm_flush, bus.mw_flush, bus.md_start};
            chk("ctrl{pc,fb,db,xb,mb,ff,df,xf,mf,ms}", {22'd0, a}, {22'd0, x.c});
            chk("stall_count", {16'd0, bus.stall_count}, {16'd0, x.cnt});
        end
    end

    initial begin
        logic [31:0] nop, lw_r5, lw_r0, add_r5, add_r0, mul, dv;
        int          base;
        nop    = 32'h0;
        lw_r5  = r_ins(8, 5, 1, 0, 0);
        lw_r0  = r_ins(8, 0, 1, 0, 0);
        add_r5 = r_ins(0, 6, 5, 7, 0);
        add_r0 = r_ins(0, 6, 0, 7, 0);
        mul    = r_ins(0, 3, 1, 2, 6);
        dv     = r_ins(0, 4, 1, 2, 7);

        reset_n          = 1'b0;
        bus.ir_fd        = '0;
        bus.ir_dx        = '0;
        bus.branch_taken = 1'b0;
        bus.md_ready     = 1'b0;
        bus.freeze       = 1'b0;

        repeat (3) cyc(nop, nop, 0, 0, 0, 0);
        repeat (2) cyc(nop, nop, 0, 0, 0, 1);

        // load-use: lw r5 then add r6,r5,r7
        base = m_count;
        cyc(add_r5, lw_r5, 0, 0, 0, 1);
        cyc(add_r5, nop, 0, 0, 0, 1);
        @(negedge clock);
        #1;
        chk("lu_count", {16'd0, bus.stall_count}, 32'(base + 1));

        // load into r0 never stalls
        cyc(add_r0, lw_r0, 0, 0, 0, 1);
        // branch wins over load-use
        cyc(add_r5, lw_r5, 1, 0, 0, 1);
        cyc(nop, nop, 0, 0, 0, 1);

        // mul with md_ready 32 cycles after start
        base = m_count;
        cyc(nop, mul, 0, 0, 0, 1);
        repeat (31) cyc(nop, mul, 0, 0, 0, 1);
        cyc(nop, mul, 0, 1, 0, 1);
        cyc(nop, nop, 0, 0, 0, 1);
        @(negedge clock);
        #1;
        chk("md32_count", {16'd0, bus.stall_count}, 32'(base + 32));

        // freeze across md_ready, release once freeze drops
        cyc(nop, dv, 0, 0, 0, 1);
        repeat (3) cyc(nop, dv, 0, 0, 0, 1);
        repeat (2) cyc(nop, dv, 0, 0, 1, 1);
        cyc(nop, dv, 0, 1, 1, 1);
        cyc(nop, dv, 0, 0, 1, 1);
        cyc(nop, dv, 0, 0, 0, 1);
        cyc(nop, nop, 0, 0, 0, 1);

        for (int i = 0; i < 1500; i++) begin
            cyc(rnd_instr(), m_busy ? mul : rnd_instr(),
                $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0,
                $urandom_range(0, 9) == 0, $urandom_range(0, 199) != 0);
        end
        cyc(nop, nop, 0, 0, 0, 0);
        cyc(nop, nop, 0, 0, 0, 1);

        // long multdiv drives the counter into saturation
        cyc(nop, mul, 0, 0, 0, 1);
        repeat (65600) cyc(nop, mul, 0, 0, 0, 1);
        @(negedge clock);
        #1;
        chk("sat_count", {16'd0, bus.stall_count}, 32'h0000ffff);

        // reset in the middle of MD_BUSY
        cyc(nop, mul, 0, 0, 0, 0);
        @(negedge clock);
        #1;
        chk("rst_busy_count", {16'd0, bus.stall_count}, 32'h0);
        repeat (3) cyc(nop, nop, 0, 0, 0, 1);
        cyc(add_r5, lw_r5, 0, 0, 0, 1);
        cyc(nop, nop, 0, 0, 0, 1);

        repeat (2) @(negedge clock);
        #1;
        chk("queue_drain", 32'(sb_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have port clock, input, 1 bit, sole clock, rising edge.
REQ-002 SHALL have port reset_n, input, 1 bit, asynchronous active-low reset.
REQ-003 SHALL have port ir_fd, input, 32 bits, instruction held in FD register (decode stage).
REQ-004 SHALL have port ir_dx, input, 32 bits, instruction held in DX register (execute stage).
REQ-005 SHALL have port branch_taken, input, 1 bit, branch/jump in X resolved taken this cycle.
REQ-006 SHALL have port md_ready, input, 1 bit, multdiv unit result valid (one-cycle pulse).
REQ-007 SHALL have port freeze, input, 1 bit, external hold of the whole pipeline.
REQ-008 SHALL have port pc_en, output, 1 bit, PC register enable.
REQ-009 SHALL have ports fd_block, dx_block, xm_block, mw_block, output, 1 bit each, hold the stage register.
REQ-010 SHALL have ports fd_flush, dx_flush, xm_flush, mw_flush, output, 1 bit each, clear the stage register at the next edge.
REQ-011 SHALL have port md_start, output, 1 bit, one-cycle multdiv start pulse.
REQ-012 SHALL have port stall_count, output, 16 bits, saturating hazard-stall cycle counter.

Function
REQ-013 SHALL decode opcode [31:27], rd [26:22], rs [21:17], rt [16:12], ALU op [6:2].
REQ-014 SHALL classify ir_dx as multdiv when opcode is 00000 and ALU op is 00110 (mul) or 00111 (div).
REQ-015 SHALL detect load-use when ir_dx opcode is 01000 (lw), its rd is nonzero, and it equals ir_fd rs, ir_fd rt (ir_fd opcode 00000), or ir_fd rd (ir_fd opcode 00111, 00010, or 00110).
REQ-016 SHALL implement FSM states IDLE, MD_BUSY.
REQ-017 SHALL move IDLE->MD_BUSY and assert md_start for exactly one cycle when ir_dx is multdiv, freeze=0, and branch_taken=0.
REQ-018 SHALL assert pc_en=0, fd_block=1, dx_block=1, xm_flush=1 in MD_BUSY and in the md_start cycle.
REQ-019 SHALL hold a sticky md_done flag in MD_BUSY, set by md_ready and cleared on leaving MD_BUSY.
REQ-020 SHALL move MD_BUSY->IDLE in the first cycle freeze=0 with md_ready or md_done set. In that cycle it SHALL release all stalls so XM captures the result.
REQ-021 SHALL force, when branch_taken=1 (not frozen, not MD_BUSY), fd_flush=1, dx_flush=1, pc_en=1, and ignore load-use that cycle.
REQ-022 SHALL force, on load-use (no higher priority), pc_en=0, fd_block=1, dx_flush=1 for one cycle.
REQ-023 SHALL use priority freeze > MD_BUSY/md_start > branch_taken > load-use > normal.
REQ-024 SHALL force, on freeze=1, pc_en=0, all *_block=1, all *_flush=0, md_start=0, with FSM state held.
REQ-025 SHALL use normal outputs pc_en=1, all block and flush 0.
REQ-026 SHALL never assert block and flush on the same stage together.
REQ-027 SHALL keep mw_flush and xm_block at 0 except under freeze (xm_block=1).
REQ-028 SHALL increment stall_count by 1 each cycle pc_en=0 with freeze=0, and saturate at 16'hFFFF.
REQ-029 SHALL derive all outputs except stall_count combinationally from state and inputs. Consumers sample them at the next rising edge.

Reset
REQ-030 SHALL, while reset_n=0, force state IDLE, md_done 0, stall_count 0, md_start 0, pc_en 0, all block 0, all flush 1.
REQ-031 SHALL, on reset during MD_BUSY, return to IDLE with no md_start reissued until ir_dx is re-evaluated after release.

Structure
REQ-032 SHALL place opcode/ALU-op constants and the FSM state type in shared package pipe_ctrl_pkg.
REQ-033 SHALL isolate load-use and multdiv classification in combinational sub-module hazard_detect.

Verification
REQ-034 SHALL check: lw r5 in DX, add r6,r5,r7 in FD -> one cycle pc_en=0, fd_block=1, dx_flush=1, stall_count 0->1.
REQ-035 SHALL check: mul in DX, md_ready after 32 cycles -> md_start one pulse, 32 stall cycles, release on md_ready cycle.
REQ-036 SHALL check: branch_taken=1 with simultaneous load-use -> fd_flush=dx_flush=1, pc_en=1, no stall.
REQ-037 SHALL check: freeze=1 during MD_BUSY with md_ready pulse -> stays MD_BUSY, releases first cycle after freeze drops.
REQ-038 SHALL check: lw r0 in DX, FD reads r0 -> no stall.
REQ-039 SHALL check: preload stall_count near 16'hFFFF via long multdiv -> holds 16'hFFFF; reset_n=0 mid-MD_BUSY -> IDLE, count 0.
